vproc_cache_arbiter: RTL and testbench

Two-to-one request arbiter directly upstream of the vector-processor data cache. It merges the scalar core data port (port A) and the vector load/store unit port (port B) onto the single CPU-side request interface of the cache. It tracks the source of every granted request so each in-order cache response returns to the requester that issued it.

---
 rtl/vproc_cache_arbiter.sv | 136 +++++++++++++
 tb/tb_vproc_cache_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vproc_cache_arbiter.sv
// Two-to-one arbiter between the scalar data port (A) and the vector LSU port (B) in front of the data cache.
// It keeps a FIFO of granted sources so that in-order cache responses are steered back to the requester.
module vproc_cache_arbiter #(
  parameter int unsigned ADDR_BIT_W      = 32,
  parameter int unsigned DATA_BYTE_W     = 4,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       a_req_i,
  input  logic [ADDR_BIT_W-1:0]      a_addr_i,
  input  logic                       a_we_i,
  input  logic [DATA_BYTE_W-1:0]     a_be_i,
  input  logic [DATA_BYTE_W*8-1:0]   a_wdata_i,
  output logic                       a_gnt_o,
  output logic                       a_rvalid_o,
  output logic [DATA_BYTE_W*8-1:0]   a_rdata_o,
  output logic                       a_err_o,
  input  logic                       b_req_i,
  input  logic [ADDR_BIT_W-1:0]      b_addr_i,
  input  logic                       b_we_i,
  input  logic [DATA_BYTE_W-1:0]     b_be_i,
  input  logic [DATA_BYTE_W*8-1:0]   b_wdata_i,
  output logic                       b_gnt_o,
  output logic                       b_rvalid_o,
  output logic [DATA_BYTE_W*8-1:0]   b_rdata_o,
  output logic                       b_err_o,
  output logic                       cache_req_o,
  output logic [ADDR_BIT_W-1:0]      cache_addr_o,
  output logic                       cache_we_o,
  output logic [DATA_BYTE_W-1:0]     cache_be_o,
  output logic [DATA_BYTE_W*8-1:0]   cache_wdata_o,
  input  logic                       cache_gnt_i,
  input  logic                       cache_rvalid_i,
  input  logic [DATA_BYTE_W*8-1:0]   cache_rdata_i,
  input  logic                       cache_err_i
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);

  // Lock state folds lock_q and lock_src_q into one encoding.
  typedef enum logic [1:0] {LOCK_NONE, LOCK_A, LOCK_B} lock_e;

  lock_e                      r_lock, w_lock_next;
  logic                       r_prio;
  logic [MAX_OUTSTANDING-1:0] r_src;
  logic [PTR_W-1:0]           r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]           r_cnt;

  logic w_sel, w_full, w_push, w_pop, w_head;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    w_sel = 1'b0;
    unique case (r_lock)
      LOCK_A:  w_sel = 1'b0;
      LOCK_B:  w_sel = 1'b1;
      default: w_sel = (a_req_i & b_req_i) ? r_prio : b_req_i;
    endcase
  end

  // Full is taken from registered state only, so a same-cycle pop cannot reopen the request path.
  assign w_full        = (r_cnt == CNT_MAX);
  assign cache_req_o   = (a_req_i | b_req_i) & ~w_full;
  assign cache_addr_o  = w_sel ? b_addr_i  : a_addr_i;
  assign cache_we_o    = w_sel ? b_we_i    : a_we_i;
  assign cache_be_o    = w_sel ? b_be_i    : a_be_i;
  assign cache_wdata_o = w_sel ? b_wdata_i : a_wdata_i;

  assign w_push  = cache_req_o & cache_gnt_i;
  assign a_gnt_o = w_push & ~w_sel;
  assign b_gnt_o = w_push &  w_sel;

  assign w_pop      = cache_rvalid_i & (r_cnt != '0);
  assign w_head     = r_src[r_rd_ptr];
  assign a_rvalid_o = w_pop & ~w_head;
  assign b_rvalid_o = w_pop &  w_head;
  assign a_rdata_o  = cache_rdata_i;
  assign b_rdata_o  = cache_rdata_i;
  assign a_err_o    = cache_err_i;
  assign b_err_o    = cache_err_i;

  always_comb begin
    w_lock_next = r_lock;
    if (w_push) begin
      w_lock_next = LOCK_NONE;
    end else if (cache_req_o) begin
      w_lock_next = w_sel ? LOCK_B : LOCK_A;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_lock <= LOCK_NONE;
    end else begin
      r_lock <= w_lock_next;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_prio   <= 1'b0;
      r_src    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) begin
        r_src[r_wr_ptr] <= w_sel;
        r_wr_ptr        <= ptr_inc(r_wr_ptr);
        r_prio          <= ~w_sel;
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

`ifndef SYNTHESIS
  a_no_orphan_rvalid: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(cache_rvalid_i && (r_cnt == '0)))
    else $error("cache_rvalid_i with no outstanding request");
`endif

endmodule

// File: tb/tb_vproc_cache_arbiter.sv
// Bench for vproc_cache_arbiter: directed vector table, hand-written wrap/reset sequences,
// and random traffic checked against a queue-based model of the arbitration rules.
module tb_vproc_cache_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DB = 4;
  localparam int unsigned MO = 2;
  localparam logic [AW-1:0] A_ADDR = 32'h0000_1000;
  localparam logic [AW-1:0] B_ADDR = 32'h0000_2000;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            a_req_i, b_req_i, a_we_i, b_we_i;
  logic [AW-1:0]   a_addr_i, b_addr_i;
  logic [DB-1:0]   a_be_i, b_be_i;
  logic [DB*8-1:0] a_wdata_i, b_wdata_i;
  logic            a_gnt_o, b_gnt_o, a_rvalid_o, b_rvalid_o, a_err_o, b_err_o;
  logic [DB*8-1:0] a_rdata_o, b_rdata_o;
  logic            cache_req_o, cache_we_o, cache_gnt_i, cache_rvalid_i, cache_err_i;
  logic [AW-1:0]   cache_addr_o;
  logic [DB-1:0]   cache_be_o;
  logic [DB*8-1:0] cache_wdata_o, cache_rdata_i;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  vproc_cache_arbiter #(
    .ADDR_BIT_W(AW),
    .DATA_BYTE_W(DB),
    .MAX_OUTSTANDING(MO)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .a_req_i(a_req_i), .a_addr_i(a_addr_i), .a_we_i(a_we_i), .a_be_i(a_be_i),
    .a_wdata_i(a_wdata_i), .a_gnt_o(a_gnt_o), .a_rvalid_o(a_rvalid_o),
    .a_rdata_o(a_rdata_o), .a_err_o(a_err_o),
    .b_req_i(b_req_i), .b_addr_i(b_addr_i), .b_we_i(b_we_i), .b_be_i(b_be_i),
    .b_wdata_i(b_wdata_i), .b_gnt_o(b_gnt_o), .b_rvalid_o(b_rvalid_o),
    .b_rdata_o(b_rdata_o), .b_err_o(b_err_o),
    .cache_req_o(cache_req_o), .cache_addr_o(cache_addr_o), .cache_we_o(cache_we_o),
    .cache_be_o(cache_be_o), .cache_wdata_o(cache_wdata_o), .cache_gnt_i(cache_gnt_i),
    .cache_rvalid_i(cache_rvalid_i), .cache_rdata_i(cache_rdata_i), .cache_err_i(cache_err_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_idle();
    a_req_i = 1'b0; a_addr_i = A_ADDR; a_we_i = 1'b0; a_be_i = 4'hF; a_wdata_i = '0;
    b_req_i = 1'b0; b_addr_i = B_ADDR; b_we_i = 1'b1; b_be_i = 4'h3; b_wdata_i = 32'h55AA_55AA;
    cache_gnt_i = 1'b0; cache_rvalid_i = 1'b0; cache_rdata_i = '0; cache_err_i = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    drive_idle();
    rst_ni = 1'b0;
    #2;
    chk("rst_req",  64'(cache_req_o), 64'd0);
    chk("rst_gnt",  64'({a_gnt_o, b_gnt_o}), 64'd0);
    chk("rst_rv",   64'({a_rvalid_o, b_rvalid_o}), 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    chk("rst_cnt",  64'(dut.r_cnt), 64'd0);
    chk("rst_prio", 64'(dut.r_prio), 64'd0);
  endtask

  // Directed vector table
  typedef struct {
    bit            rst;
    bit            a, b, g, rv;
    logic [31:0]   rdata;
    bit            e_req, e_ag, e_bg, e_arv, e_brv;
    logic [AW-1:0] e_addr;
  } vec_t;

  function automatic vec_t mk(bit rst, bit a, bit b, bit g, bit rv, logic [31:0] rd,
                              bit er, bit eag, bit ebg, bit earv, bit ebrv, logic [AW-1:0] ea);
    vec_t v;
    v.rst = rst; v.a = a; v.b = b; v.g = g; v.rv = rv; v.rdata = rd;
    v.e_req = er; v.e_ag = eag; v.e_bg = ebg; v.e_arv = earv; v.e_brv = ebrv; v.e_addr = ea;
    return v;
  endfunction

  // Reference model: outstanding sources in a queue, plus priority and held selection
  bit m_prio, m_lock, m_lsrc;
  bit m_q[$];
  bit a_done, b_done;

  task automatic model_check();
    bit full, sel, ereq, eg, pop, head;
    full = (m_q.size() == MO);
    sel  = m_lock ? m_lsrc : ((a_req_i && b_req_i) ? m_prio : b_req_i);
    ereq = (a_req_i || b_req_i) && !full;
    eg   = ereq && cache_gnt_i;
    pop  = cache_rvalid_i && (m_q.size() != 0);
    head = pop ? m_q[0] : 1'b0;
    chk("m_req",   64'(cache_req_o), 64'(ereq));
    chk("m_a_gnt", 64'(a_gnt_o), 64'(eg && !sel));
    chk("m_b_gnt", 64'(b_gnt_o), 64'(eg && sel));
    chk("m_a_rv",  64'(a_rvalid_o), 64'(pop && !head));
    chk("m_b_rv",  64'(b_rvalid_o), 64'(pop && head));
    if (ereq) begin
      chk("m_addr",  64'(cache_addr_o),  64'(sel ? b_addr_i  : a_addr_i));
      chk("m_we",    64'(cache_we_o),    64'(sel ? b_we_i    : a_we_i));
      chk("m_be",    64'(cache_be_o),    64'(sel ? b_be_i    : a_be_i));
      chk("m_wdata", 64'(cache_wdata_o), 64'(sel ? b_wdata_i : a_wdata_i));
    end
    if (pop) begin
      chk("m_rdata", 64'({a_rdata_o, b_rdata_o}), 64'({cache_rdata_i, cache_rdata_i}));
      chk("m_err",   64'({a_err_o, b_err_o}), 64'({cache_err_i, cache_err_i}));
      void'(m_q.pop_front());
    end
    a_done = eg && !sel;
    b_done = eg && sel;
    if (eg) begin
      m_q.push_back(sel);
      m_prio = !sel;
      m_lock = 1'b0;
    end else if (ereq) begin
      m_lock = 1'b1;
      m_lsrc = sel;
    end
  endtask

  initial begin
    vec_t tbl[20];
    tbl[0]  = mk(1, 1,0,1,0, 32'h0,        1,1,0,0,0, A_ADDR);
    tbl[1]  = mk(0, 0,0,0,0, 32'h0,        0,0,0,0,0, '0);
    tbl[2]  = mk(0, 0,0,0,1, 32'hDEADBEEF, 0,0,0,1,0, '0);
    tbl[3]  = mk(1, 1,1,1,0, 32'h0,        1,1,0,0,0, A_ADDR);
    tbl[4]  = mk(0, 1,1,1,1, 32'h11111111, 1,0,1,1,0, B_ADDR);
    tbl[5]  = mk(0, 1,1,1,1, 32'h22222222, 1,1,0,0,1, A_ADDR);
    tbl[6]  = mk(0, 1,1,1,1, 32'h33333333, 1,0,1,1,0, B_ADDR);
    tbl[7]  = mk(0, 0,0,0,1, 32'h44444444, 0,0,0,0,1, '0);
    tbl[8]  = mk(1, 1,0,1,0, 32'h0,        1,1,0,0,0, A_ADDR);
    tbl[9]  = mk(0, 0,0,0,1, 32'h5,        0,0,0,1,0, '0);
    tbl[10] = mk(0, 1,0,0,0, 32'h0,        1,0,0,0,0, A_ADDR);
    tbl[11] = mk(0, 1,1,0,0, 32'h0,        1,0,0,0,0, A_ADDR);
    tbl[12] = mk(0, 1,1,0,0, 32'h0,        1,0,0,0,0, A_ADDR);
    tbl[13] = mk(0, 1,1,1,0, 32'h0,        1,1,0,0,0, A_ADDR);
    tbl[14] = mk(0, 0,1,1,0, 32'h0,        1,0,1,0,0, B_ADDR);
    tbl[15] = mk(0, 1,0,1,0, 32'h0,        0,0,0,0,0, '0);
    tbl[16] = mk(0, 1,0,1,1, 32'h6,        0,0,0,1,0, '0);
    tbl[17] = mk(0, 1,0,1,0, 32'h0,        1,1,0,0,0, A_ADDR);
    tbl[18] = mk(0, 0,0,0,1, 32'h7,        0,0,0,0,1, '0);
    tbl[19] = mk(0, 0,0,0,1, 32'h8,        0,0,0,1,0, '0);

    drive_idle();
    rst_ni = 1'b1;

    for (int i = 0; i < 20; i++) begin
      if (tbl[i].rst) do_reset();
      @(negedge clk_i);
      drive_idle();
      a_req_i = tbl[i].a; b_req_i = tbl[i].b;
      cache_gnt_i = tbl[i].g; cache_rvalid_i = tbl[i].rv; cache_rdata_i = tbl[i].rdata;
      #2;
      chk($sformatf("v%0d_req", i),   64'(cache_req_o), 64'(tbl[i].e_req));
      chk($sformatf("v%0d_a_gnt", i), 64'(a_gnt_o),     64'(tbl[i].e_ag));
      chk($sformatf("v%0d_b_gnt", i), 64'(b_gnt_o),     64'(tbl[i].e_bg));
      chk($sformatf("v%0d_a_rv", i),  64'(a_rvalid_o),  64'(tbl[i].e_arv));
      chk($sformatf("v%0d_b_rv", i),  64'(b_rvalid_o),  64'(tbl[i].e_brv));
      if (tbl[i].e_req) begin
        chk($sformatf("v%0d_addr", i), 64'(cache_addr_o), 64'(tbl[i].e_addr));
        chk($sformatf("v%0d_we", i),   64'(cache_we_o),   64'(tbl[i].e_addr == B_ADDR));
      end
      if (tbl[i].rv) begin
        chk($sformatf("v%0d_rdata_a", i), 64'(a_rdata_o), 64'(tbl[i].rdata));
        chk($sformatf("v%0d_rdata_b", i), 64'(b_rdata_o), 64'(tbl[i].rdata));
      end
    end

    // Same-cycle push/pop at one outstanding, ten transactions across pointer wrap
    do_reset();
    @(negedge clk_i);
    a_req_i = 1'b1; cache_gnt_i = 1'b1;
    #2;
    chk("wrap_first_a_gnt", 64'(a_gnt_o), 64'd1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_i);
      a_req_i = 1'b1; b_req_i = 1'b1; cache_gnt_i = 1'b1;
      cache_rvalid_i = 1'b1; cache_rdata_i = 32'(k);
      #2;
      chk($sformatf("wrap%0d_cnt", k),   64'(dut.r_cnt), 64'd1);
      chk($sformatf("wrap%0d_req", k),   64'(cache_req_o), 64'd1);
      chk($sformatf("wrap%0d_b_gnt", k), 64'(b_gnt_o), 64'(k % 2 == 0));
      chk($sformatf("wrap%0d_a_gnt", k), 64'(a_gnt_o), 64'(k % 2 == 1));
      chk($sformatf("wrap%0d_a_rv", k),  64'(a_rvalid_o), 64'(k % 2 == 0));
      chk($sformatf("wrap%0d_b_rv", k),  64'(b_rvalid_o), 64'(k % 2 == 1));
    end
    @(negedge clk_i);
    drive_idle();
    cache_rvalid_i = 1'b1;
    #2;
    chk("wrap_drain_a_rv", 64'(a_rvalid_o), 64'd1);
    chk("wrap_drain_b_rv", 64'(b_rvalid_o), 64'd0);

    // Reset with two outstanding, then a lone B request
    do_reset();
    @(negedge clk_i);
    a_req_i = 1'b1; cache_gnt_i = 1'b1;
    #2;
    chk("rst2_a_gnt", 64'(a_gnt_o), 64'd1);
    @(negedge clk_i);
    a_req_i = 1'b0; b_req_i = 1'b1; cache_gnt_i = 1'b1;
    #2;
    chk("rst2_b_gnt", 64'(b_gnt_o), 64'd1);
    @(negedge clk_i);
    #1;
    chk("rst2_cnt_full", 64'(dut.r_cnt), 64'd2);
    do_reset();
    @(negedge clk_i);
    b_req_i = 1'b1; cache_gnt_i = 1'b1;
    #2;
    chk("rst2_lone_b_req", 64'(cache_req_o), 64'd1);
    chk("rst2_lone_b_gnt", 64'(b_gnt_o), 64'd1);
    chk("rst2_lone_addr",  64'(cache_addr_o), 64'(B_ADDR));

    // Random traffic against the queue model
    do_reset();
    m_prio = 1'b0; m_lock = 1'b0; m_lsrc = 1'b0; m_q.delete();
    a_done = 1'b0; b_done = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk_i);
      if (!a_req_i || a_done) begin
        a_req_i = ($urandom_range(0, 2) != 0);
        a_addr_i = $urandom; a_we_i = 1'($urandom); a_be_i = 4'($urandom); a_wdata_i = $urandom;
      end
      if (!b_req_i || b_done) begin
        b_req_i = ($urandom_range(0, 2) != 0);
        b_addr_i = $urandom; b_we_i = 1'($urandom); b_be_i = 4'($urandom); b_wdata_i = $urandom;
      end
      cache_gnt_i    = ($urandom_range(0, 3) != 0);
      cache_rvalid_i = (m_q.size() != 0) && ($urandom_range(0, 1) != 0);
      cache_rdata_i  = $urandom;
      cache_err_i    = 1'($urandom);
      #2;
      model_check();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
